// File: rtl/johnson_seq_gen.sv
// johnson_seq_gen: programmable twisted-ring (Johnson) sequence generator.
// Steps a WIDTH-bit Johnson register either continuously through a prescaler
// (RUN) or once per single-step rising edge (IDLE), in either direction. It also
// provides clear, load, sticky illegal-state detection, and tick/wrap strobes.
//
// Optional feature macro: JOHNSON_SELF_CORRECT_EN
//   defined     -> an advance from an illegal q loads 0 (tick and wrap both fire)
//   not defined -> illegal states shift like any other value
module johnson_seq_gen #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             run,
  input  logic             step,
  input  logic             dir,
  input  logic [DIV_W-1:0] div,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             wrap,
  output logic             err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-2:0] DIFF_ONE = 1;
  localparam logic [DIV_W-1:0] PC_ONE   = 1;

  state_t           state;
  state_t           state_next;
  logic [DIV_W-1:0] pc;
  logic [DIV_W-1:0] pc_next;
  logic             step_d;
  logic             step_edge;
  logic             advance;
  logic             illegal;
  logic [WIDTH-2:0] diff;
  logic [WIDTH-1:0] q_adv;

  assign step_edge = step & ~step_d;

  // Legal Johnson codes have at most one boundary between adjacent bits.
  always_comb begin
    diff    = q[WIDTH-2:0] ^ q[WIDTH-1:1];
    illegal = (diff & (diff - DIFF_ONE)) != '0;
  end

  // Value q takes on an advance: one twisted-ring shift in the selected direction.
  always_comb begin
    q_adv = dir ? {~q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], ~q[WIDTH-1]};
`ifdef JOHNSON_SELF_CORRECT_EN
    if (illegal) begin
      q_adv = '0;
    end
`endif
  end

  // Next-state, prescaler and advance decision.
  // NOTE: every output of this block is given a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    advance    = 1'b0;
    unique case (state)
      IDLE: begin
        advance = step_edge;
        if (run) begin
          state_next = RUN;
          pc_next    = '0;
        end
      end
      RUN: begin
        if (!run) begin
          state_next = IDLE;
          pc_next    = '0;
        end else if (pc >= div) begin
          // >= so that lowering div mid-run advances on the next enabled edge.
          advance = 1'b1;
          pc_next = '0;
        end else begin
          pc_next = pc + PC_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        pc_next    = '0;
      end
    endcase
  end

  // FSM state register; clr and ld leave the run/idle mode alone.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_next;
    end
  end

  // Datapath registers: priority clr > ld > advance on each enabled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q      <= '0;
      pc     <= '0;
      tick   <= 1'b0;
      wrap   <= 1'b0;
      err    <= 1'b0;
      step_d <= 1'b1;  // a step held through reset is not an edge
    end else if (ena) begin
      step_d <= step;
      tick   <= 1'b0;
      wrap   <= 1'b0;
      if (clr) begin
        q   <= '0;
        pc  <= '0;
        err <= 1'b0;
      end else begin
        err <= err | illegal;
        if (ld) begin
          q  <= ld_val;
          pc <= '0;
        end else begin
          pc <= pc_next;
          if (advance) begin
            q    <= q_adv;
            tick <= 1'b1;
            wrap <= (q_adv == '0);
          end
        end
      end
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_johnson_seq_gen.sv
// Directed bench for johnson_seq_gen: a vector table for the free-running walk
// plus clear/load, followed by hand-written multi-cycle sequences for prescaler,
// single-step, illegal-state, enable-freeze and asynchronous-reset behaviour.
module tb_johnson_seq_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic       dir = 1'b0;
  logic [3:0] div = 4'd0;
  logic       clr = 1'b0;
  logic       ld = 1'b0;
  logic [7:0] ld_val = 8'h00;
  logic [7:0] q;
  logic       tick;
  logic       wrap;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  johnson_seq_gen #(.WIDTH(8), .DIV_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .run(run), .step(step), .dir(dir),
    .div(div), .clr(clr), .ld(ld), .ld_val(ld_val),
    .q(q), .tick(tick), .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       run;
    logic       step;
    logic       dir;
    logic [3:0] div;
    logic       clr;
    logic       ld;
    logic [7:0] ld_val;
    logic [7:0] exp_q;
    logic       exp_tick;
    logic       exp_wrap;
    logic       exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_out(input string name, input logic [7:0] eq, input logic et,
                            input logic ew, input logic ee);
    check({name, ".q"},    {24'd0, q}, {24'd0, eq});
    check({name, ".tick"}, {31'd0, tick}, {31'd0, et});
    check({name, ".wrap"}, {31'd0, wrap}, {31'd0, ew});
    check({name, ".err"},  {31'd0, err}, {31'd0, ee});
  endtask

  task automatic drive(input logic r, input logic s, input logic d, input logic [3:0] dv,
                       input logic c, input logic l, input logic [7:0] lv);
    run = r; step = s; dir = d; div = dv; clr = c; ld = l; ld_val = lv;
  endtask

  // One active edge, then settle to the falling edge for sampling/driving.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic d, input logic [3:0] dv,
                              input logic c, input logic l, input logic [7:0] lv,
                              input logic [7:0] eq, input logic et, input logic ew,
                              input logic ee);
    vec_t v;
    v.run = r; v.step = s; v.dir = d; v.div = dv; v.clr = c; v.ld = l; v.ld_val = lv;
    v.exp_q = eq; v.exp_tick = et; v.exp_wrap = ew; v.exp_err = ee;
    return v;
  endfunction

  logic [7:0] walk [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                            8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};

  initial begin
    int ticks;
    logic [7:0] eq;

    // Table: RUN entry, full left walk at div=0, then clr, ld, advance, drop run.
    tbl.push_back(mk(1, 0, 0, 4'd0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(1, 0, 0, 4'd0, 0, 0, 8'h00, walk[i], 1, (i == 15), 0));
    tbl.push_back(mk(1, 0, 0, 4'd0, 1, 0, 8'h00, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'd0, 0, 1, 8'h07, 8'h07, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'd0, 0, 0, 8'h00, 8'h0F, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'd0, 0, 0, 8'h00, 8'h0F, 0, 0, 0));

    // Reset state.
    #2;
    expect_out("reset", 8'h00, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].run, tbl[i].step, tbl[i].dir, tbl[i].div, tbl[i].clr, tbl[i].ld, tbl[i].ld_val);
      cyc();
      expect_out($sformatf("vec%0d", i), tbl[i].exp_q, tbl[i].exp_tick, tbl[i].exp_wrap,
                 tbl[i].exp_err);
    end

    // Prescaler div=3: first advance on the 4th edge after RUN entry.
    drive(1, 0, 0, 4'd3, 0, 0, 8'h00);
    cyc();
    expect_out("div3_entry", 8'h0F, 0, 0, 0);
    eq = 8'h0F;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (k == 4) eq = 8'h1F;
      if (k == 8) eq = 8'h3F;
      check($sformatf("div3_e%0d.tick", k), {31'd0, tick}, {31'd0, (k % 4) == 0});
      check($sformatf("div3_e%0d.q", k), {24'd0, q}, {24'd0, eq});
    end
    // Drop run with pc mid-count: no further advances.
    run = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      expect_out($sformatf("drop_e%0d", k), 8'h3F, 0, 0, 0);
    end
    // Re-entry starts the count from zero again.
    run = 1'b1;
    cyc();
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check($sformatf("rerun_e%0d.tick", k), {31'd0, tick}, {31'd0, k == 4});
    end
    check("rerun.q", {24'd0, q}, 32'h7F);

    // Single-step: clear, then step held high for 5 cycles going right.
    drive(0, 0, 1, 4'd0, 1, 0, 8'h00);
    cyc();
    expect_out("step_clr", 8'h00, 0, 0, 0);
    drive(0, 1, 1, 4'd0, 0, 0, 8'h00);
    ticks = 0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      ticks += int'(tick);
      check($sformatf("step_hold%0d.q", k), {24'd0, q}, 32'h80);
    end
    check("step_hold.ticks", ticks, 1);
    step = 1'b0;
    cyc();
    expect_out("step_low", 8'h80, 0, 0, 0);
    step = 1'b1;
    cyc();
    expect_out("step2", 8'hC0, 1, 0, 0);
    step = 1'b0;
    cyc();
    drive(0, 1, 1, 4'd0, 1, 0, 8'h00);
    cyc();
    expect_out("step_and_clr", 8'h00, 0, 0, 0);
    drive(0, 0, 0, 4'd0, 0, 0, 8'h00);
    cyc();

    // Illegal load: err rises one edge later and is sticky until clr.
    drive(0, 0, 0, 4'd0, 0, 1, 8'h5A);
    cyc();
    expect_out("ld5a", 8'h5A, 0, 0, 0);
    drive(0, 0, 0, 4'd0, 0, 0, 8'h00);
    cyc();
    expect_out("ld5a_err", 8'h5A, 0, 0, 1);
    step = 1'b1;
    cyc();
`ifdef JOHNSON_SELF_CORRECT_EN
    expect_out("illegal_step", 8'h00, 1, 1, 1);
`else
    expect_out("illegal_step", 8'hB5, 1, 0, 1);
`endif
    step = 1'b0;
    cyc();
    check("err_sticky", {31'd0, err}, 32'd1);
    clr = 1'b1;
    cyc();
    expect_out("err_clr", 8'h00, 0, 0, 0);
    clr = 1'b0;
    cyc();
    expect_out("after_clr", 8'h00, 0, 0, 0);

    // Enable freeze mid-run at div=2.
    drive(1, 0, 0, 4'd2, 0, 0, 8'h00);
    cyc();
    cyc();
    cyc();
    check("frz_pre.tick", {31'd0, tick}, 32'd0);
    cyc();
    expect_out("frz_adv1", 8'h01, 1, 0, 0);
    cyc();
    expect_out("frz_pc1", 8'h01, 0, 0, 0);
    ena = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      expect_out($sformatf("frz%0d", k), 8'h01, 0, 0, 0);
    end
    ena = 1'b1;
    cyc();
    expect_out("resume_pc2", 8'h01, 0, 0, 0);
    cyc();
    expect_out("resume_adv", 8'h03, 1, 0, 0);

    // Asynchronous reset between edges while running with err set.
    drive(1, 0, 0, 4'd0, 0, 1, 8'h5A);
    cyc();
    expect_out("pre_rst_ld", 8'h5A, 0, 0, 0);
    ld = 1'b0;
    cyc();
    check("pre_rst.err", {31'd0, err}, 32'd1);
    check("pre_rst.tick", {31'd0, tick}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    expect_out("async_rst", 8'h00, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    expect_out("rst_held", 8'h00, 0, 0, 0);
    rst_n = 1'b1;
    cyc();
    expect_out("post_rst_entry", 8'h00, 0, 0, 0);
    cyc();
    expect_out("post_rst_adv", 8'h01, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/johnson_seq_gen.md
# johnson_seq_gen

Programmable twisted-ring (Johnson) sequence generator that produces the pattern stream consumed by the registered pad-output stage of the Johnson top level. It steps a WIDTH-bit Johnson register either continuously through a prescaler or one step per single-step request, in either direction. It also provides load, clear, illegal-state detection and wrap/tick strobes.

## Interface
- WIDTH, 8, Johnson register width; the legal sequence has 2*WIDTH states.
- DIV_W, 4, prescaler divide-control width.

- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  global enable; when low, all registers hold and tick/wrap are 0.
- run  in  1  level; continuous stepping while high.
- step  in  1  single-step request; acted on at its rising edge, only in IDLE.
- dir  in  1  0 = left (q <= {q[W-2:0], ~q[W-1]}); 1 = right (q <= {~q[0], q[W-1:1]}).
- div  in  DIV_W  prescaler; RUN advances once every div+1 enabled cycles.
- clr  in  1  synchronous clear.
- ld  in  1  synchronous load of ld_val.
- ld_val  in  WIDTH  load value; any value accepted.
- q  out  WIDTH  Johnson state, registered.
- tick  out  1  high for the one cycle after each advance edge.
- wrap  out  1  high for the one cycle after an advance that produced q == 0.
- err  out  1  sticky illegal-state flag.

## Operation
- Legal state: at most one position i (0..W-2) where q[i] != q[i+1]. Both directions share the same legal set.
- FSM states:
  - IDLE to RUN when run = 1; pc <= 0.
  - RUN to IDLE when run = 0; pc <= 0.
- Step edge: step & ~step_d; step_d updates only when ena = 1.
- Advance conditions:
  - IDLE: on a step edge.
  - RUN: when pc >= div; then pc <= 0, otherwise pc <= pc + 1.
  - Step edges are ignored in RUN.
  - Using >= means lowering div mid-run gives an advance on the next enabled edge.
- Per enabled edge, priority is clr > ld > advance:
  - clr: q <= 0, pc <= 0, err <= 0; no tick, no wrap; FSM state unchanged.
  - ld: q <= ld_val, pc <= 0; no tick, no wrap.
  - advance: shift per dir; tick <= 1; wrap <= (next q == 0).
- Any edge without an advance: tick <= 0, wrap <= 0.
- err <= err | illegal(q) on every enabled edge unless clr is asserted. The check is on the current registered q.
- ena = 0: q, pc, FSM, step_d and err hold; tick and wrap <= 0.

## Timing
- Reset (asynchronous, immediate): q = 0, tick = 0, wrap = 0, err = 0, FSM = IDLE, pc = 0, step_d = 1.
  - step_d = 1 means a step held high through reset is not counted.
  - Reset mid-operation aborts everything; no strobe is emitted.
- Step latency: q updates on the same edge that first samples step high; tick is visible in the following cycle, together with the new q.
- RUN latency: the first advance comes div+1 enabled edges after the IDLE-to-RUN edge; advances repeat every div+1 enabled edges.
  - div = 0 gives one advance per enabled cycle.
- Wrap: occurs every 2*WIDTH advances when starting from 0 in a fixed direction. A direction change mid-sequence is legal and reverses the walk.
- err rises one edge after an illegal q is first present; it stays high until clr or reset.

## Configuration
- JOHNSON_SELF_CORRECT_EN defined: an advance from an illegal q loads q <= 0 instead of shifting. tick is 1 and wrap is 1 for that advance. err is still set.
- Not defined: illegal states shift normally (q may stay illegal indefinitely); err detection is unchanged.

## Test plan
- Reset, then run = 1, div = 0, dir = 0: q walks 01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80,00. tick is high every cycle; wrap is high only with 00; err stays 0.
- run = 1, div = 3: the first advance is on the 4th edge after RUN entry, then every 4 edges. Drop run: no further advances and pc returns to 0.
- IDLE, dir = 1, step held high for 5 cycles: q 00 to 80, exactly one tick. A second pulse gives C0. step and clr together give q = 00, no tick.
- ld_val = 5A: err = 1 on the next edge. Then one step:
  - with the macro, q = 00 with tick and wrap;
  - without it, q = B5.
  - In both cases err stays 1 until clr.
- Mid-run (div = 2), ena low for 10 cycles: q, pc and err are frozen and tick = 0. On resume the advance phase continues exactly where it stopped.
- rst_n pulsed low asynchronously between clock edges during RUN: q = 00, err = 0 and tick = 0 immediately. FSM is IDLE after release until run is sampled.
